// File: rtl/pipe_acc_2p_if.sv
// pipe_acc_2p_if: sample/frame-result bundle between the adder-side master and pipe_acc_2p
interface pipe_acc_2p_if #(parameter int IN_WIDTH = 15, ACC_WIDTH = 24);
   logic                 start;
   logic                 in_valid;
   logic [IN_WIDTH-1:0]  in_data;
   logic                 busy;
   logic                 out_valid;
   logic [ACC_WIDTH-1:0] acc_out;
   logic                 ovf;
   modport master(output start, in_valid, in_data, input busy, out_valid, acc_out, ovf);
   modport slave(input start, in_valid, in_data, output busy, out_valid, acc_out, ovf);
endinterface

// File: rtl/pipe_acc_2p.sv
// pipe_acc_2p: frame accumulator with split LSB/MSB halves and a registered inter-half carry
// PIPE_ACC_SAT_EN: acc_out saturates to all ones while ovf is set
module pipe_acc_2p #(
   parameter int IN_WIDTH  = 15,
   parameter int ACC_WIDTH = 24,
   parameter int LSB_WIDTH = 12,
   parameter int NSAMP     = 16
) (
   input logic clk,
   input logic rst,
   pipe_acc_2p_if.slave bus
);
   localparam int MW = ACC_WIDTH - LSB_WIDTH;
   localparam int CW = $clog2(NSAMP + 1);
   typedef enum logic [1:0] {IDLE, ACC, FLUSH, DONE} state_t;
   state_t               state, state_n;
   logic [LSB_WIDTH-1:0] lsb_q, lsb_n;
   logic [MW-1:0]        msb_q, msb_n;
   logic                 c_q, c_n, ovf_q, ovf_n, take;
   logic [CW-1:0]        cnt, cnt_n;
   logic [ACC_WIDTH-1:0] din;
   logic [LSB_WIDTH:0]   lsum;
   logic [MW:0]          msum;
   assign take = state == ACC && bus.in_valid;
   assign din  = ACC_WIDTH'(bus.in_data);
   assign lsum = {1'b0, lsb_q} + {1'b0, din[LSB_WIDTH-1:0]};
   // MSB half always absorbs the previous cycle's carry; sample bits only when one is taken
   assign msum = {1'b0, msb_q} + (MW+1)'(c_q) + (take ? {1'b0, din[ACC_WIDTH-1:LSB_WIDTH]} : '0);
   always_comb begin
      state_n = state;
      lsb_n   = lsb_q;
      msb_n   = msb_q;
      c_n     = c_q;
      ovf_n   = ovf_q;
      cnt_n   = cnt;
      case (state)
         IDLE: if (bus.start) begin
            state_n = ACC;
            lsb_n   = '0;
            msb_n   = '0;
            c_n     = 1'b0;
            ovf_n   = 1'b0;
            cnt_n   = '0;
         end
         ACC: begin
            msb_n = msum[MW-1:0];
            ovf_n = ovf_q | msum[MW];
            c_n   = take ? lsum[LSB_WIDTH] : 1'b0;
            if (take) begin
               lsb_n   = lsum[LSB_WIDTH-1:0];
               cnt_n   = cnt + CW'(1);
               state_n = cnt == CW'(NSAMP - 1) ? FLUSH : ACC;
            end
         end
         FLUSH: begin
            msb_n   = msum[MW-1:0];
            ovf_n   = ovf_q | msum[MW];
            c_n     = 1'b0;
            state_n = DONE;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         lsb_q <= '0;
         msb_q <= '0;
         c_q   <= 1'b0;
         ovf_q <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         lsb_q <= lsb_n;
         msb_q <= msb_n;
         c_q   <= c_n;
         ovf_q <= ovf_n;
         cnt   <= cnt_n;
      end
   assign bus.busy      = state != IDLE;
   assign bus.out_valid = state == DONE;
   assign bus.ovf       = ovf_q;
`ifdef PIPE_ACC_SAT_EN
   assign bus.acc_out   = ovf_q ? '1 : {msb_q, lsb_q};
`else
   assign bus.acc_out   = {msb_q, lsb_q};
`endif
endmodule

// File: tb/tb_pipe_acc_2p.sv
// tb_pipe_acc_2p: scoreboarded frame tests on a 24-bit and a 16-bit accumulator instance
module tb_pipe_acc_2p;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [24:0] qa[$];
   logic [16:0] qb[$];
   pipe_acc_2p_if #(.IN_WIDTH(15), .ACC_WIDTH(24)) a();
   pipe_acc_2p_if #(.IN_WIDTH(15), .ACC_WIDTH(16)) b();
   pipe_acc_2p #(.IN_WIDTH(15), .ACC_WIDTH(24), .LSB_WIDTH(12), .NSAMP(4)) dut_a(.clk(clk), .rst(rst), .bus(a));
   pipe_acc_2p #(.IN_WIDTH(15), .ACC_WIDTH(16), .LSB_WIDTH(8), .NSAMP(4)) dut_b(.clk(clk), .rst(rst), .bus(b));
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (a.out_valid) begin
         total++;
         if (qa.size() == 0) begin
            bad++;
            $display("FAIL sb_a_unexpected acc_out=%h ovf=%b", a.acc_out, a.ovf);
         end else begin
            logic [24:0] e;
            e = qa.pop_front();
            if ({a.acc_out, a.ovf} !== e) begin
               bad++;
               $display("FAIL sb_a got acc_out=%h ovf=%b want acc_out=%h ovf=%b", a.acc_out, a.ovf, e[24:1], e[0]);
            end
         end
      end
      if (b.out_valid) begin
         total++;
         if (qb.size() == 0) begin
            bad++;
            $display("FAIL sb_b_unexpected acc_out=%h ovf=%b", b.acc_out, b.ovf);
         end else begin
            logic [16:0] e;
            e = qb.pop_front();
            if ({b.acc_out, b.ovf} !== e) begin
               bad++;
               $display("FAIL sb_b got acc_out=%h ovf=%b want acc_out=%h ovf=%b", b.acc_out, b.ovf, e[16:1], e[0]);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic start_a();
      a.start = 1'b1;
      cyc();
      a.start = 1'b0;
   endtask

   task automatic samp_a(input logic [14:0] d);
      a.in_valid = 1'b1;
      a.in_data  = d;
      cyc();
      a.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 20) begin
         cyc();
         n++;
      end
      total++;
      if (qa.size() != 0 || qb.size() != 0) begin
         bad++;
         $display("FAIL drain_timeout pending_a=%0d pending_b=%0d want 0", qa.size(), qb.size());
         qa.delete();
         qb.delete();
      end
      cyc();
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #1;
      total++;
      if ({a.busy, a.out_valid, a.ovf, a.acc_out} !== 27'd0) begin
         bad++;
         $display("FAIL reset_a busy=%b ov=%b ovf=%b acc=%h want all 0", a.busy, a.out_valid, a.ovf, a.acc_out);
      end
      total++;
      if ({b.busy, b.out_valid, b.ovf, b.acc_out} !== 19'd0) begin
         bad++;
         $display("FAIL reset_b busy=%b ov=%b ovf=%b acc=%h want all 0", b.busy, b.out_valid, b.ovf, b.acc_out);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      cyc();
   endtask

   task automatic test_basic();
      qa.push_back({24'd10, 1'b0});
      start_a();
      samp_a(15'd1);
      samp_a(15'd2);
      samp_a(15'd3);
      samp_a(15'd4);
      @(negedge clk);
      total++;
      if (a.out_valid !== 1'b0 || a.busy !== 1'b1) begin
         bad++;
         $display("FAIL lat_flush out_valid=%b busy=%b want 0 1", a.out_valid, a.busy);
      end
      @(negedge clk);
      total++;
      if (a.out_valid !== 1'b1) begin
         bad++;
         $display("FAIL lat_done out_valid=%b want 1", a.out_valid);
      end
      @(negedge clk);
      total++;
      if (a.out_valid !== 1'b0 || a.busy !== 1'b0 || a.acc_out !== 24'd10) begin
         bad++;
         $display("FAIL pulse_end out_valid=%b busy=%b acc=%h want 0 0 00000a", a.out_valid, a.busy, a.acc_out);
      end
      drain();
   endtask

   task automatic test_carry();
      qa.push_back({24'h010FFE, 1'b0});
      start_a();
      samp_a(15'h0FFF);
      samp_a(15'h0001);
      samp_a(15'h7FFF);
      samp_a(15'h7FFF);
      drain();
   endtask

   task automatic test_gaps();
      logic [14:0] d[4] = '{15'd7, 15'd0, 15'd9, 15'd1};
      int g[4] = '{1, 3, 2, 0};
      qa.push_back({24'd17, 1'b0});
      start_a();
      for (int i = 0; i < 4; i++) begin
         samp_a(d[i]);
         for (int j = 0; j < g[i]; j++) begin
            @(negedge clk);
            total++;
            if (a.busy !== 1'b1) begin
               bad++;
               $display("FAIL gap_busy sample=%0d busy=%b want 1", i, a.busy);
            end
            cyc();
         end
      end
      drain();
   endtask

   task automatic test_overflow();
`ifdef PIPE_ACC_SAT_EN
      qb.push_back({16'hFFFF, 1'b1});
`else
      qb.push_back({16'hFFFC, 1'b1});
`endif
      b.start = 1'b1;
      cyc();
      b.start = 1'b0;
      b.in_valid = 1'b1;
      b.in_data  = 15'h7FFF;
      repeat (4) cyc();
      b.in_valid = 1'b0;
      drain();
      total++;
      if (b.ovf !== 1'b1) begin
         bad++;
         $display("FAIL ovf_sticky ovf=%b want 1", b.ovf);
      end
      qb.push_back({16'd4, 1'b0});
      b.start = 1'b1;
      cyc();
      b.start = 1'b0;
      total++;
      if (b.ovf !== 1'b0 || b.acc_out !== 16'd0) begin
         bad++;
         $display("FAIL ovf_clear ovf=%b acc=%h want 0 0000", b.ovf, b.acc_out);
      end
      b.in_valid = 1'b1;
      b.in_data  = 15'd1;
      repeat (4) cyc();
      b.in_valid = 1'b0;
      drain();
   endtask

   task automatic test_mid_reset();
      start_a();
      samp_a(15'd5);
      samp_a(15'd5);
      #2 rst = 1'b1;
      #1;
      total++;
      if ({a.busy, a.out_valid, a.ovf, a.acc_out} !== 27'd0) begin
         bad++;
         $display("FAIL mid_reset busy=%b ov=%b ovf=%b acc=%h want all 0", a.busy, a.out_valid, a.ovf, a.acc_out);
      end
      @(negedge clk);
      rst = 1'b0;
      cyc();
      qa.push_back({24'd20, 1'b0});
      start_a();
      repeat (4) samp_a(15'd5);
      drain();
   endtask

   task automatic test_back_to_back();
      qa.push_back({24'd4, 1'b0});
      a.start    = 1'b1;
      a.in_valid = 1'b1;
      a.in_data  = 15'd100;
      cyc();
      a.start    = 1'b0;
      a.in_data  = 15'd1;
      repeat (4) cyc();
      a.in_data  = 15'd50;
      repeat (4) cyc();
      a.in_valid = 1'b0;
      drain();
      total++;
      if (a.acc_out !== 24'd4 || a.busy !== 1'b0 || a.ovf !== 1'b0) begin
         bad++;
         $display("FAIL done_ignore acc=%h busy=%b ovf=%b want 000004 0 0", a.acc_out, a.busy, a.ovf);
      end
   endtask

   initial begin
      a.start = 1'b0; a.in_valid = 1'b0; a.in_data = '0;
      b.start = 1'b0; b.in_valid = 1'b0; b.in_data = '0;
      test_reset();
      test_basic();
      test_carry();
      test_gaps();
      test_overflow();
      test_mid_reset();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
